// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch/execute handshake and decoded-head bundle for decode_queue
interface decode_queue_if #(
  parameter int CNT_W = 3
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_inst;
  logic [31:0]      i_pc;
  logic             o_valid;
  logic             i_ready;
  logic             i_conflict;
  logic             i_flush;
  logic [6:0]       o_op;
  logic [2:0]       o_func;
  logic [4:0]       o_reg_rd;
  logic [4:0]       o_reg_rs1;
  logic [4:0]       o_reg_rs2;
  logic             o_reg_wen;
  logic [31:0]      o_imm;
  logic [31:0]      o_pc;
  logic [1:0]       o_csr_t;
  logic [CNT_W-1:0] o_count;

  modport master (
    output i_valid, i_inst, i_pc, i_ready, i_conflict, i_flush,
    input  o_ready, o_valid, o_op, o_func, o_reg_rd, o_reg_rs1, o_reg_rs2,
           o_reg_wen, o_imm, o_pc, o_csr_t, o_count
  );

  modport slave (
    input  i_valid, i_inst, i_pc, i_ready, i_conflict, i_flush,
    output o_ready, o_valid, o_op, o_func, o_reg_rd, o_reg_rs1, o_reg_rs2,
           o_reg_wen, o_imm, o_pc, o_csr_t, o_count
  );
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - circular instruction queue with combinational decode of the head entry
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic          i_clock,
  input  logic          i_reset,
  decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [31:0]      head;
  logic [6:0]       op;
  logic [2:0]       func;
  logic [31:0]      imm;

  // Handshake flags come from registered count only, so no input reaches them.
  assign bus.o_ready = (count != CNT_W'(DEPTH));
  assign bus.o_valid = (count != '0);
  assign push = bus.i_valid && bus.o_ready && !bus.i_flush;
  assign pop  = bus.o_valid && bus.i_ready && !bus.i_conflict && !bus.i_flush;

  always_ff @(posedge i_clock) begin
    if (i_reset || bus.i_flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge i_clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.i_inst;
      pc_mem[wr_ptr]   <= bus.i_pc;
    end
  end

  assign head = inst_mem[rd_ptr];
  assign op   = head[6:0];
  assign func = head[14:12];

  always_comb begin
    imm = {25'b0, head[31:25]};
    case (op)
      7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011:
        imm = {{20{head[31]}}, head[31:20]};
      7'b0100011:
        imm = {{20{head[31]}}, head[31:25], head[11:7]};
      7'b1100011:
        imm = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {head[31:12], 12'b0};
      7'b1101111:
        imm = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      default:
        imm = {25'b0, head[31:25]};
    endcase
  end

  assign bus.o_op      = op;
  assign bus.o_func    = func;
  assign bus.o_reg_rd  = head[11:7];
  assign bus.o_reg_rs1 = head[19:15];
  assign bus.o_reg_rs2 = head[24:20];
  assign bus.o_reg_wen = !((op == 7'b0100011) || (op == 7'b1100011));
  assign bus.o_imm     = imm;
  assign bus.o_pc      = pc_mem[rd_ptr];
  assign bus.o_csr_t   = (func != 3'b000) ? 2'b01 : (head[29] ? 2'b00 : 2'b11);
  assign bus.o_count   = count;
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized scoreboard bench for decode_queue
module tb_decode_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic i_clock;
  logic i_reset;
  decode_queue_if #(.CNT_W(3)) bus ();

  decode_queue #(.DEPTH(DEPTH), .CNT_W(3)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  ent_t        exp_q[$];
  int          mcount;
  int          total;
  int          bad;
  bit          mon_en;
  logic [31:0] pc_ctr;
  logic [6:0]  ops [11];

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int s;
    int hi;
    logic [6:0] op;
    s  = $signed(w);
    op = w[6:0];
    if (op inside {7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011}) begin
      hi = s >>> 20;
      return hi;
    end
    if (op == 7'b0100011) begin
      hi = s >>> 25;
      return hi * 32 + 32'(w[11:7]);
    end
    if (op == 7'b1100011) begin
      hi = s >>> 31;
      return hi * 4096 + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
    end
    if (op == 7'b0110111 || op == 7'b0010111) return w & 32'hFFFFF000;
    if (op == 7'b1101111) begin
      hi = s >>> 31;
      return hi * 1048576 + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
    end
    return w / 33554432;
  endfunction

  function automatic logic [31:0] rinst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  // Monitor: checks occupancy every cycle and the head against the scoreboard front.
  always @(negedge i_clock) begin
    if (mon_en) begin
      chk("count", 32'(bus.o_count), mcount);
      chk("valid", 32'(bus.o_valid), 32'(mcount != 0));
      chk("ready", 32'(bus.o_ready), 32'(mcount != DEPTH));
      if (mcount != 0) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("op",    32'(bus.o_op),      32'(exp_q[0].inst[6:0]));
          chk("func",  32'(bus.o_func),    32'(exp_q[0].inst[14:12]));
          chk("rd",    32'(bus.o_reg_rd),  32'(exp_q[0].inst[11:7]));
          chk("rs1",   32'(bus.o_reg_rs1), 32'(exp_q[0].inst[19:15]));
          chk("rs2",   32'(bus.o_reg_rs2), 32'(exp_q[0].inst[24:20]));
          chk("wen",   32'(bus.o_reg_wen),
              32'(!(exp_q[0].inst[6:0] == 7'b0100011 || exp_q[0].inst[6:0] == 7'b1100011)));
          chk("imm",   bus.o_imm,          ref_imm(exp_q[0].inst));
          chk("pc",    bus.o_pc,           exp_q[0].pc);
          chk("csr_t", 32'(bus.o_csr_t),
              (exp_q[0].inst[14:12] != 0) ? 32'd1 : (exp_q[0].inst[29] ? 32'd0 : 32'd3));
          if (bus.i_ready && !bus.i_conflict && !bus.i_flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drives one cycle of inputs and advances the occupancy model across the edge.
  task automatic drive(input bit v, input logic [31:0] inst, input bit r,
                       input bit c, input bit f, input bit rs);
    bit push;
    bit pop;
    int nxt;
    ent_t e;
    bus.i_valid    = v;
    bus.i_inst     = inst;
    bus.i_pc       = pc_ctr;
    bus.i_ready    = r;
    bus.i_conflict = c;
    bus.i_flush    = f;
    i_reset        = rs;
    push = v && (mcount != DEPTH) && !f;
    pop  = (mcount != 0) && r && !c && !f;
    if (push && !rs) begin
      e.inst = inst;
      e.pc   = pc_ctr;
      exp_q.push_back(e);
    end
    nxt = mcount + int'(push) - int'(pop);
    pc_ctr = pc_ctr + 32'd4;
    @(posedge i_clock);
    #1;
    if (rs || f) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      mcount = nxt;
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, r, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111};
    total = 0;
    bad = 0;
    mcount = 0;
    mon_en = 1'b0;
    pc_ctr = 32'h0000_1000;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    chk("reset_count", 32'(bus.o_count), 32'd0);
    chk("reset_ready", 32'(bus.o_ready), 32'd1);
    chk("reset_valid", 32'(bus.o_valid), 32'd0);

    // Fill past capacity with downstream stalled, then drain.
    for (int i = 0; i < 5; i++) drive(1'b1, rinst(), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(bus.o_count), 32'd4);
    chk("full_ready", 32'(bus.o_ready), 32'd0);
    idle(5, 1'b1);
    chk("drained_valid", 32'(bus.o_valid), 32'd0);

    // Steady push+pop at occupancy 2 wraps both pointers.
    for (int i = 0; i < 2; i++) drive(1'b1, rinst(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, rinst(), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pushpop_count", 32'(bus.o_count), 32'd2);
    idle(3, 1'b1);

    drive(1'b1, 32'hFFF00093, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("addi_imm", bus.o_imm, 32'hFFFFFFFF);
    chk("addi_wen", 32'(bus.o_reg_wen), 32'd1);
    drive(1'b1, 32'hFE000EE3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("beq_imm", bus.o_imm, 32'hFFFFFFFC);
    chk("beq_wen", 32'(bus.o_reg_wen), 32'd0);
    idle(2, 1'b1);

    drive(1'b1, 32'h30200073, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mret_csr", 32'(bus.o_csr_t), 32'd0);
    drive(1'b1, 32'h00000073, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ecall_csr", 32'(bus.o_csr_t), 32'd3);
    drive(1'b1, 32'h30529073, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("csrw_csr", 32'(bus.o_csr_t), 32'd1);
    idle(2, 1'b1);

    // Conflict holds the head while occupancy stays at 3.
    for (int i = 0; i < 3; i++) drive(1'b1, rinst(), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("conflict_count", 32'(bus.o_count), 32'd3);
    idle(4, 1'b1);

    // Flush wins over a same-cycle push.
    for (int i = 0; i < 2; i++) drive(1'b1, rinst(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, rinst(), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(bus.o_count), 32'd0);
    chk("flush_valid", 32'(bus.o_valid), 32'd0);
    drive(1'b1, rinst(), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_flush_valid", 32'(bus.o_valid), 32'd1);
    idle(2, 1'b1);

    // Reset mid-operation wins over flush and push.
    for (int i = 0; i < 3; i++) drive(1'b1, rinst(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, rinst(), 1'b0, 1'b0, 1'b1, 1'b1);
    chk("midreset_count", 32'(bus.o_count), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, rinst(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 22) == 0,
            $urandom_range(0, 96) == 0);
    end
    idle(6, 1'b1);
    chk("final_empty", 32'(bus.o_valid), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
